// File: rtl/clk_div_bank.sv
// ---------------------------------------------------------------------------
// clk_div_bank
//
// Bank of N_CH independent programmable clock dividers sharing one master
// clock. Each channel counts enabled cycles up to its divisor register and
// then produces a terminal event. A terminal event does three things:
//   - the counter reloads 0
//   - tick pulses high for one cycle
//   - clk_out toggles (square mode) or mirrors tick (pulse mode)
//
// Parameters
//   N_CH     : number of divider channels (1..8)
//   CNT_W    : width of each counter and divisor register
//   DIV_INIT : packed reset divisors; channel i occupies slice i
//
// Ports
//   master_clk : system clock; every flop uses its rising edge
//   rst        : synchronous, active-high reset; also reloads DIV_INIT
//   en[i]      : count enable for channel i
//   mode[i]    : 0 = square (toggle on terminal), 1 = pulse (follows tick)
//   sync       : one-cycle restart of every channel in phase
//   div_wr     : divisor write strobe
//   div_sel    : channel addressed by div_wr; out-of-range values are dropped
//   div_val    : divisor value written by div_wr
//   clk_out[i] : registered divided clock
//   tick[i]    : registered one-cycle terminal strobe
// ---------------------------------------------------------------------------
module clk_div_bank #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 27,
  parameter logic [N_CH*CNT_W-1:0] DIV_INIT =
    {27'd12500000, 27'd125000, 27'd25000000, 27'd50000000}
) (
  input  logic             master_clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  en,
  input  logic [N_CH-1:0]  mode,
  input  logic             sync,
  input  logic             div_wr,
  input  logic [2:0]       div_sel,
  input  logic [CNT_W-1:0] div_val,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick
);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic [CNT_W-1:0] div_reg, div_next;
      logic             clk_out_reg, clk_out_next;
      logic             tick_reg, tick_next;
      logic             terminal;
      logic             wr_hit;

      // div_sel is 3 bits and channels never exceed 8, so an exact match on
      // the channel index is all that is needed; indices >= N_CH have no
      // channel to match and are dropped naturally.
      assign wr_hit = div_wr && (div_sel == 3'(gi));

      // ">=" rather than "==": when the divisor is lowered below the running
      // count the channel terminates on the next enabled cycle instead of
      // wrapping through the whole counter range. The comparison uses the
      // current divisor, so a write landing on a terminal cycle only takes
      // effect for the following period.
      assign terminal = en[gi] && (cnt_reg >= div_reg);

      always_comb begin
        cnt_next     = cnt_reg;
        div_next     = div_reg;
        clk_out_next = clk_out_reg;
        tick_next    = 1'b0;

        if (wr_hit) begin
          div_next = div_val;
        end

        if (sync) begin
          // Phase restart; the divisor write above still goes through.
          cnt_next     = '0;
          clk_out_next = 1'b0;
          tick_next    = 1'b0;
        end else begin
          if (terminal) begin
            cnt_next = '0;
          end else if (en[gi]) begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
          tick_next = terminal;
          // Pulse mode mirrors tick; square mode toggles from whatever value
          // clk_out currently holds, so a mode change needs no re-sync.
          if (mode[gi]) begin
            clk_out_next = terminal;
          end else if (terminal) begin
            clk_out_next = ~clk_out_reg;
          end
        end
      end

      always_ff @(posedge master_clk) begin
        if (rst) begin
          cnt_reg     <= '0;
          div_reg     <= DIV_INIT[gi*CNT_W +: CNT_W];
          clk_out_reg <= 1'b0;
          tick_reg    <= 1'b0;
        end else begin
          cnt_reg     <= cnt_next;
          div_reg     <= div_next;
          clk_out_reg <= clk_out_next;
          tick_reg    <= tick_next;
        end
      end

      assign clk_out[gi] = clk_out_reg;
      assign tick[gi]    = tick_reg;
    end
  endgenerate

endmodule

// File: tb/tb_clk_div_bank.sv
module tb_clk_div_bank;

  localparam int N_CH  = 4;
  localparam int CNT_W = 8;

  logic             master_clk = 1'b0;
  logic             rst;
  logic [N_CH-1:0]  en;
  logic [N_CH-1:0]  mode;
  logic             sync;
  logic             div_wr;
  logic [2:0]       div_sel;
  logic [CNT_W-1:0] div_val;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  tick;

  clk_div_bank #(
    .N_CH    (N_CH),
    .CNT_W   (CNT_W),
    .DIV_INIT({8'd3, 8'd2, 8'd1, 8'd0})
  ) dut (
    .master_clk(master_clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .sync      (sync),
    .div_wr    (div_wr),
    .div_sel   (div_sel),
    .div_val   (div_val),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  always #5 master_clk = ~master_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_div [N_CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge master_clk);
    #1;
  endtask

  // Square-mode expectation after a restart (reset release or sync): with the
  // counter starting at 0, edge k is a terminal when k is a multiple of
  // div+1, and clk_out has toggled floor(k/(div+1)) times.
  task automatic run_check(input int n, input logic [N_CH-1:0] mask, input string tag);
    logic [N_CH-1:0] et, ec;
    for (int k = 1; k <= n; k++) begin
      step();
      et = '0;
      ec = '0;
      for (int ch = 0; ch < N_CH; ch++) begin
        if (mask[ch]) begin
          et[ch] = ((k % (exp_div[ch] + 1)) == 0);
          ec[ch] = (((k / (exp_div[ch] + 1)) % 2) == 1);
        end
      end
      check($sformatf("%s_tick_k%0d", tag, k), 32'(tick & mask), 32'(et));
      check($sformatf("%s_clk_k%0d", tag, k), 32'(clk_out & mask), 32'(ec));
    end
  endtask

  initial begin
    rst = 1'b1; sync = 1'b0; div_wr = 1'b0; div_sel = '0; div_val = '0;
    en = 4'hF; mode = 4'h0;

    // Reset state
    step(); step();
    check("reset_clk_out", 32'(clk_out), 32'h0);
    check("reset_tick", 32'(tick), 32'h0);
    rst = 1'b0;
    $display("[TB] reset done");

    // Square mode with reset divisors {3,2,1,0}
    exp_div = '{0, 1, 2, 3};
    run_check(16, 4'hF, "init");
    $display("[TB] square mode from reset checked");

    // Pulse mode on ch1, div=4, with an enable gap
    mode = 4'b0010; sync = 1'b1; div_wr = 1'b1; div_sel = 3'd1; div_val = 8'd4;
    step();
    sync = 1'b0; div_wr = 1'b0;
    check("pulse_sync_clk", 32'(clk_out), 32'h0);
    check("pulse_sync_tick", 32'(tick), 32'h0);
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("pulse_tick_k%0d", k), 32'(tick[1]), 32'((k % 5) == 0));
      check($sformatf("pulse_clk_k%0d", k), 32'(clk_out[1]), 32'((k % 5) == 0));
    end
    en = 4'b1101;
    for (int j = 1; j <= 7; j++) begin
      step();
      check($sformatf("gap_tick_%0d", j), 32'(tick[1]), 32'h0);
      check($sformatf("gap_clk_%0d", j), 32'(clk_out[1]), 32'h0);
    end
    en = 4'hF;
    for (int j = 1; j <= 3; j++) begin
      step();
      check($sformatf("resume_tick_%0d", j), 32'(tick[1]), 32'(j == 3));
    end
    $display("[TB] pulse mode and enable gap checked");

    // Divisor lowered below the running count
    mode = 4'h0; sync = 1'b1; div_wr = 1'b1; div_sel = 3'd0; div_val = 8'd200;
    step();
    sync = 1'b0; div_wr = 1'b0;
    repeat (150) step();
    check("lower_pre_tick", 32'(tick[0]), 32'h0);
    check("lower_pre_clk", 32'(clk_out[0]), 32'h0);
    div_wr = 1'b1; div_sel = 3'd0; div_val = 8'd10;
    step();
    div_wr = 1'b0;
    check("lower_wr_tick", 32'(tick[0]), 32'h0);
    for (int j = 1; j <= 23; j++) begin
      step();
      check($sformatf("lower_tick_%0d", j), 32'(tick[0]), 32'(j == 1 || j == 12 || j == 23));
      check($sformatf("lower_clk_%0d", j), 32'(clk_out[0]), 32'(((j + 10) / 11) % 2));
    end
    $display("[TB] divisor lowering checked");

    // Write coinciding with a terminal on ch2
    sync = 1'b1; div_wr = 1'b1; div_sel = 3'd2; div_val = 8'd5;
    step();
    sync = 1'b0; div_wr = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 6) begin
        div_wr = 1'b1; div_sel = 3'd2; div_val = 8'd9;
      end
      step();
      div_wr = 1'b0;
      check($sformatf("coinc_tick_k%0d", k), 32'(tick[2]), 32'(k == 6 || k == 16));
    end
    $display("[TB] coincident write checked");

    // Scramble phases, then sync
    div_wr = 1'b1; div_sel = 3'd0; div_val = 8'd3; en = 4'b1010;
    step();
    div_sel = 3'd1;
    step();
    div_wr = 1'b0;
    step(); step();
    en = 4'hF;
    step(); step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_clk", 32'(clk_out), 32'h0);
    check("sync_tick", 32'(tick), 32'h0);
    exp_div = '{3, 3, 9, 3};
    run_check(12, 4'hF, "sync");
    $display("[TB] sync lockstep checked");

    // rst with sync and a write: divisors back to init, write discarded
    rst = 1'b1; sync = 1'b1; div_wr = 1'b1; div_sel = 3'd0; div_val = 8'd77;
    step();
    rst = 1'b0; sync = 1'b0; div_wr = 1'b0;
    check("rst_sync_clk", 32'(clk_out), 32'h0);
    check("rst_sync_tick", 32'(tick), 32'h0);
    exp_div = '{0, 1, 2, 3};
    run_check(16, 4'hF, "rst_sync");
    $display("[TB] rst with sync checked");

    // Out-of-range channel select must not touch any divisor
    div_wr = 1'b1; div_sel = 3'd5; div_val = 8'd0; sync = 1'b1;
    step();
    div_wr = 1'b0; sync = 1'b0;
    run_check(12, 4'hF, "bad_sel");
    $display("[TB] out-of-range select checked");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
